// File: rtl/mc_ctrl.sv
// rtl/mc_ctrl.sv - multicycle control sequencer for the 10-bit lab MIPS datapath
// Optional feature: define MC_ILLEGAL_TRAP_EN to halt with err=1 on opcodes A-E.
module mc_ctrl #(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] opcode,
  input  logic       zero,
  input  logic       mem_ack,
  output logic       mem_re,
  output logic       mem_we,
  output logic       ir_we,
  output logic       pc_we,
  output logic       reg_we,
  output logic [1:0] pc_src,
  output logic       ext_en,
  output logic       ext_sign,
  output logic       alu_srcb,
  output logic [2:0] alu_op,
  output logic       mem_to_reg,
  output logic       halted,
  output logic [1:0] err,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_BRANCH = 3'd6,
    S_HALT   = 3'd7
  } state_e;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_AND = 3'd2;
  localparam logic [2:0] ALU_OR  = 3'd3;

  state_e     state_q, state_d;
  logic [3:0] opc_q, opc_d;
  logic [3:0] tmo_q, tmo_d;
  logic [1:0] err_q, err_d;
  logic       tmo_hit;

  // An ack in the same cycle as the last allowed wait takes priority over the timeout.
  assign tmo_hit = (tmo_q == 4'(MEM_TIMEOUT - 1)) && !mem_ack;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      opc_q   <= 4'd0;
      tmo_q   <= 4'd0;
      err_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      opc_q   <= opc_d;
      tmo_q   <= tmo_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    opc_d      = opc_q;
    err_d      = err_q;
    tmo_d      = 4'd0;
    mem_re     = 1'b0;
    mem_we     = 1'b0;
    ir_we      = 1'b0;
    pc_we      = 1'b0;
    reg_we     = 1'b0;
    pc_src     = 2'd0;
    ext_en     = 1'b0;
    ext_sign   = 1'b0;
    alu_srcb   = 1'b0;
    alu_op     = ALU_ADD;
    mem_to_reg = 1'b0;
    halted     = 1'b0;
    case (state_q)
      S_IDLE: state_d = S_FETCH;
      S_FETCH: begin
        mem_re = 1'b1;
        if (mem_ack) begin
          ir_we   = 1'b1;
          pc_we   = 1'b1;
          state_d = S_DECODE;
        end else if (tmo_hit) begin
          state_d = S_HALT;
          err_d   = 2'd2;
        end else begin
          tmo_d = tmo_q + 4'd1;
        end
      end
      S_DECODE: begin
        ext_en   = 1'b1;
        ext_sign = (opcode != 4'd5);
        opc_d    = opcode;
        case (opcode)
          4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5: state_d = S_EXEC;
          4'd6, 4'd7: state_d = S_MEM;
          4'd8:       state_d = S_BRANCH;
          4'd9: begin
            pc_we   = 1'b1;
            pc_src  = 2'd2;
            state_d = S_FETCH;
          end
          4'hF:       state_d = S_HALT;
          default: begin
`ifdef MC_ILLEGAL_TRAP_EN
            state_d = S_HALT;
            err_d   = 2'd1;
`else
            state_d = S_FETCH;
`endif
          end
        endcase
      end
      S_EXEC: begin
        alu_srcb = (opc_q == 4'd4) || (opc_q == 4'd5);
        case (opc_q)
          4'd1:       alu_op = ALU_SUB;
          4'd2:       alu_op = ALU_AND;
          4'd3, 4'd5: alu_op = ALU_OR;
          default:    alu_op = ALU_ADD;
        endcase
        state_d = S_WB;
      end
      S_MEM: begin
        alu_srcb = 1'b1;
        mem_re   = (opc_q == 4'd6);
        mem_we   = (opc_q == 4'd7);
        if (mem_ack) begin
          state_d = (opc_q == 4'd6) ? S_WB : S_FETCH;
        end else if (tmo_hit) begin
          state_d = S_HALT;
          err_d   = 2'd2;
        end else begin
          tmo_d = tmo_q + 4'd1;
        end
      end
      S_WB: begin
        reg_we     = 1'b1;
        mem_to_reg = (opc_q == 4'd6);
        state_d    = S_FETCH;
      end
      S_BRANCH: begin
        alu_op = ALU_SUB;
        if (zero) begin
          pc_we  = 1'b1;
          pc_src = 2'd1;
        end
        state_d = S_FETCH;
      end
      S_HALT: halted = 1'b1;
      default: state_d = S_IDLE;
    endcase
  end

  assign err   = err_q;
  assign state = state_q;

endmodule

// File: tb/tb_mc_ctrl.sv
// tb/tb_mc_ctrl.sv - scoreboard bench for mc_ctrl with directed per-cycle vectors
module tb_mc_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] opcode = 4'd0;
  logic       zero = 1'b0;
  logic       mem_ack = 1'b1;
  logic       mem_re, mem_we, ir_we, pc_we, reg_we;
  logic [1:0] pc_src;
  logic       ext_en, ext_sign, alu_srcb;
  logic [2:0] alu_op;
  logic       mem_to_reg, halted;
  logic [1:0] err;
  logic [2:0] state;

  mc_ctrl #(.MEM_TIMEOUT(15)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .mem_ack(mem_ack),
    .mem_re(mem_re), .mem_we(mem_we), .ir_we(ir_we), .pc_we(pc_we), .reg_we(reg_we),
    .pc_src(pc_src), .ext_en(ext_en), .ext_sign(ext_sign), .alu_srcb(alu_srcb),
    .alu_op(alu_op), .mem_to_reg(mem_to_reg), .halted(halted), .err(err), .state(state)
  );

  always #5 clk = ~clk;

  // Layout: state_re_we_irwe_pcwe_pcsrc_exten_extsign_srcb_aluop_m2r_regwe_halted_err
  localparam logic [19:0] V_IDLE    = 20'b000_0_0_0_0_00_0_0_0_000_0_0_0_00;
  localparam logic [19:0] V_FETCH   = 20'b001_1_0_1_1_00_0_0_0_000_0_0_0_00;
  localparam logic [19:0] V_FWAIT   = 20'b001_1_0_0_0_00_0_0_0_000_0_0_0_00;
  localparam logic [19:0] V_DEC     = 20'b010_0_0_0_0_00_1_1_0_000_0_0_0_00;
  localparam logic [19:0] V_DEC_ORI = 20'b010_0_0_0_0_00_1_0_0_000_0_0_0_00;
  localparam logic [19:0] V_DEC_J   = 20'b010_0_0_0_1_10_1_1_0_000_0_0_0_00;
  localparam logic [19:0] V_EX_SUB  = 20'b011_0_0_0_0_00_0_0_0_001_0_0_0_00;
  localparam logic [19:0] V_EX_ADDI = 20'b011_0_0_0_0_00_0_0_1_000_0_0_0_00;
  localparam logic [19:0] V_EX_ORI  = 20'b011_0_0_0_0_00_0_0_1_011_0_0_0_00;
  localparam logic [19:0] V_MEM_LW  = 20'b100_1_0_0_0_00_0_0_1_000_0_0_0_00;
  localparam logic [19:0] V_MEM_SW  = 20'b100_0_1_0_0_00_0_0_1_000_0_0_0_00;
  localparam logic [19:0] V_WB      = 20'b101_0_0_0_0_00_0_0_0_000_0_1_0_00;
  localparam logic [19:0] V_WB_LW   = 20'b101_0_0_0_0_00_0_0_0_000_1_1_0_00;
  localparam logic [19:0] V_BR_T    = 20'b110_0_0_0_1_01_0_0_0_001_0_0_0_00;
  localparam logic [19:0] V_BR_N    = 20'b110_0_0_0_0_00_0_0_0_001_0_0_0_00;
  localparam logic [19:0] V_HALT0   = 20'b111_0_0_0_0_00_0_0_0_000_0_0_1_00;
  localparam logic [19:0] V_HALT1   = 20'b111_0_0_0_0_00_0_0_0_000_0_0_1_01;
  localparam logic [19:0] V_HALT2   = 20'b111_0_0_0_0_00_0_0_0_000_0_0_1_10;

  typedef struct {
    string       name;
    logic [19:0] exp;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        cur;
  int          n_checks = 0;
  int          n_pass = 0;
  logic [19:0] act;

  assign act = {state, mem_re, mem_we, ir_we, pc_we, pc_src, ext_en, ext_sign,
                alu_srcb, alu_op, mem_to_reg, reg_we, halted, err};

  task automatic step(input string name, input logic r, input logic a, input logic z,
                      input logic [3:0] op, input logic [19:0] e);
    @(negedge clk);
    rst     = r;
    mem_ack = a;
    zero    = z;
    opcode  = op;
    sb_q.push_back('{name, e});
  endtask

  always begin
    @(negedge clk);
    #2;
    if (sb_q.size() > 0) begin
      cur = sb_q.pop_front();
      n_checks++;
      if (act === cur.exp) n_pass++;
      else $display("FAIL %s actual=%b required=%b", cur.name, act, cur.exp);
    end
  end

  initial begin
    for (int i = 0; i < 3; i++) step("reset_hold", 1, 1, 0, 4'd0, V_IDLE);
    step("idle_after_rst", 0, 1, 0, 4'd4, V_IDLE);

    step("addi_fetch",  0, 1, 0, 4'd4, V_FETCH);
    step("addi_decode", 0, 1, 0, 4'd4, V_DEC);
    step("addi_exec",   0, 1, 0, 4'd0, V_EX_ADDI);
    step("addi_wb",     0, 1, 0, 4'd0, V_WB);

    step("ori_fetch",  0, 1, 0, 4'd5, V_FETCH);
    step("ori_decode", 0, 1, 0, 4'd5, V_DEC_ORI);
    step("ori_exec",   0, 1, 0, 4'd5, V_EX_ORI);
    step("ori_wb",     0, 1, 0, 4'd5, V_WB);

    step("lw_fetch",  0, 1, 0, 4'd6, V_FETCH);
    step("lw_decode", 0, 1, 0, 4'd6, V_DEC);
    for (int i = 0; i < 3; i++) step("lw_mem_wait", 0, 0, 0, 4'd6, V_MEM_LW);
    step("lw_mem_ack", 0, 1, 0, 4'd6, V_MEM_LW);
    step("lw_wb",      0, 1, 0, 4'd6, V_WB_LW);

    step("sw_fetch",  0, 1, 0, 4'd7, V_FETCH);
    step("sw_decode", 0, 1, 0, 4'd7, V_DEC);
    step("sw_mem",    0, 1, 0, 4'd7, V_MEM_SW);

    step("beq_t_fetch",  0, 1, 0, 4'd8, V_FETCH);
    step("beq_t_decode", 0, 1, 0, 4'd8, V_DEC);
    step("beq_taken",    0, 1, 1, 4'd8, V_BR_T);
    step("beq_n_fetch",  0, 1, 0, 4'd8, V_FETCH);
    step("beq_n_decode", 0, 1, 0, 4'd8, V_DEC);
    step("beq_not",      0, 1, 0, 4'd8, V_BR_N);

    step("j_fetch",  0, 1, 0, 4'd9, V_FETCH);
    step("j_decode", 0, 1, 0, 4'd9, V_DEC_J);

    step("sub_fetch",   0, 1, 0, 4'd1, V_FETCH);
    step("sub_decode",  0, 1, 0, 4'd1, V_DEC);
    step("sub_exec",    0, 1, 0, 4'd1, V_EX_SUB);
    step("rst_mid_wb",  1, 1, 0, 4'd1, V_IDLE);
    step("rst_release", 0, 1, 0, 4'hB, V_IDLE);

    step("ill_fetch",  0, 1, 0, 4'hB, V_FETCH);
    step("ill_decode", 0, 1, 0, 4'hB, V_DEC);
`ifdef MC_ILLEGAL_TRAP_EN
    step("ill_trap_halt", 0, 1, 0, 4'hB, V_HALT1);
    step("ill_trap_hold", 0, 1, 0, 4'hB, V_HALT1);
`else
    step("ill_nop_fetch", 0, 1, 0, 4'hB, V_FETCH);
`endif

    step("tmo_reset",   1, 0, 0, 4'hF, V_IDLE);
    step("tmo_release", 0, 0, 0, 4'hF, V_IDLE);
    for (int i = 0; i < 15; i++) step("tmo_fetch_wait", 0, 0, 0, 4'hF, V_FWAIT);
    step("tmo_halt",   0, 0, 0, 4'hF, V_HALT2);
    step("tmo_sticky", 0, 1, 0, 4'hF, V_HALT2);

    step("ackwin_reset",   1, 0, 0, 4'hF, V_IDLE);
    step("ackwin_release", 0, 0, 0, 4'hF, V_IDLE);
    for (int i = 0; i < 14; i++) step("ackwin_wait", 0, 0, 0, 4'hF, V_FWAIT);
    step("ackwin_ack",    0, 1, 0, 4'hF, V_FETCH);
    step("ackwin_decode", 0, 1, 0, 4'hF, V_DEC);
    step("halt_opcode",   0, 1, 0, 4'hF, V_HALT0);
    step("halt_hold",     0, 0, 0, 4'h4, V_HALT0);

    repeat (3) @(negedge clk);
    n_checks++;
    if (sb_q.size() == 0) n_pass++;
    else $display("FAIL scoreboard_drain actual=%0d required=0", sb_q.size());

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mc_ctrl.md
# mc_ctrl

Multicycle control sequencer for the 10-bit lab MIPS datapath. It decodes the 4-bit opcode held in the instruction register and steps the datapath through fetch, decode, execute, memory and write-back. It drives the enable and mode of the 6→10-bit immediate extender (`SignExt`), the ALU, the register file, the PC and the memory port. It sits between the instruction register and every datapath enable; no other block writes those enables.

## Interface
Parameters:
- `MEM_TIMEOUT`, default 15: maximum cycles waiting for `mem_ack` before a bus-error halt.

Ports:
- `clk`  in  1  system clock; all state changes on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `opcode`  in  4  instruction register [15:12]; valid from DECODE onward.
- `zero`  in  1  ALU zero flag, sampled in BRANCH.
- `mem_ack`  in  1  memory completion for the current `mem_re`/`mem_we`.
- `mem_re`, `mem_we`  out  1  memory read/write request, held until ack.
- `ir_we`, `pc_we`, `reg_we`  out  1  single-cycle write enables.
- `pc_src`  out  2  0 = PC+1, 1 = branch target, 2 = jump target.
- `ext_en`  out  1  capture enable for the immediate extender.
- `ext_sign`  out  1  1 = sign-extend, 0 = zero-extend.
- `alu_srcb`  out  1  0 = register, 1 = extended immediate.
- `alu_op`  out  3  0 ADD, 1 SUB, 2 AND, 3 OR.
- `mem_to_reg`  out  1  write-back source is memory data.
- `halted`  out  1  sticky; set in HALT.
- `err`  out  2  0 none, 1 illegal opcode, 2 memory timeout.
- `state`  out  3  current state, for debug.

## Operation
- States, with their `state` encodings:
  - IDLE=0 → FETCH unconditionally.
  - FETCH=1: `mem_re`=1. On `mem_ack`: `ir_we`=1 and `pc_we`=1 with `pc_src`=0 in that cycle, then DECODE.
  - DECODE=2: `ext_en`=1 and `ext_sign` set from the opcode. Next state by opcode:
    - 0–5 → EXEC.
    - 6, 7 → MEM.
    - 8 → BRANCH.
    - 9 → `pc_we`=1 with `pc_src`=2, then FETCH.
    - F → HALT.
    - other → see Configuration.
  - EXEC=3:
    - `alu_op` per opcode: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 ADDI→ADD, 5 ORI→OR.
    - `alu_srcb`=1 for opcodes 4 and 5.
    - Then WB.
  - MEM=4:
    - `alu_op`=ADD, `alu_srcb`=1.
    - Assert `mem_re` for opcode 6 (LW) or `mem_we` for opcode 7 (SW).
    - On ack: LW → WB; SW → FETCH.
  - WB=5: `reg_we`=1; `mem_to_reg`=1 only for LW. Then FETCH.
  - BRANCH=6: `alu_op`=SUB. If `zero`, `pc_we`=1 with `pc_src`=1. Then FETCH.
  - HALT=7: `halted`=1; remains until reset.
- `ext_sign`=0 only for opcode 5 (ORI); 1 otherwise.
- Timeout counter:
  - 4 bits; cleared on entering FETCH or MEM.
  - Increments each cycle a request is outstanding without ack.
  - Reaching `MEM_TIMEOUT` → HALT with `err`=2.

## Timing
- Reset values:
  - `state`=IDLE.
  - All request and enable outputs = 0, `pc_src`=0, `alu_op`=0, `ext_sign`=0.
  - `halted`=0, `err`=0.
- Outputs are Moore-decoded from `state` and the latched opcode. The exception is the ack-qualified enables in FETCH, MEM and BRANCH, which are combinational on `mem_ack`/`zero`.
- The opcode is latched into an internal register at the DECODE edge and stays stable through WB even if the instruction register changes.
- The extender's output is valid in EXEC/MEM: one cycle after `ext_en` in DECODE.
- Cycle counts with zero-wait memory (ack in the same cycle as the request):
  - R-type/ADDI/ORI: 4 (FETCH, DECODE, EXEC, WB).
  - LW: 4; SW: 3; BEQ: 3; J: 2.
- `mem_ack` outside FETCH/MEM is ignored.
- `rst` mid-instruction drops every output to its reset value immediately (asynchronous) with no partial write. The first FETCH follows one IDLE cycle after `rst` deasserts.
- `mem_ack` in the same cycle that the timeout is reached: the ack wins and there is no error.

## Configuration
- `MC_ILLEGAL_TRAP_EN` defined: opcodes A–E in DECODE → HALT, `err`=1.
- `MC_ILLEGAL_TRAP_EN` undefined: opcodes A–E execute as NOP, DECODE → FETCH (the PC has already advanced) and `err` stays 0.

## Test plan
- Reset held 3 cycles, then released, with `mem_ack` tied 1: `state` goes 0→1; all outputs are 0 during reset.
- ADDI (opcode 4), zero-wait memory: `ext_en` and `ext_sign`=1 in DECODE; `alu_srcb`=1 in EXEC; `reg_we` pulses exactly once on the 4th cycle after FETCH.
- ORI (opcode 5): `ext_sign`=0 in DECODE; `alu_op`=3.
- LW with `mem_ack` delayed 3 cycles in MEM: `mem_re` is held 4 cycles; then WB with `mem_to_reg`=1 and `reg_we`=1.
- BEQ with `zero`=1: `pc_we`=1, `pc_src`=1 in BRANCH. With `zero`=0: no `pc_we`.
- Fault cases:
  - `mem_ack` never asserted in FETCH: after 15 cycles → `state`=7, `err`=2, `halted`=1.
  - Opcode B with `MC_ILLEGAL_TRAP_EN`: `err`=1, HALT.
  - Opcode B without `MC_ILLEGAL_TRAP_EN`: return to FETCH with `err`=0.
